// File: rtl/prog_loader.sv
// Program loader: assembles a byte stream into machine-code words, writes them
// into instruction memory, then releases the core and tracks its done flag.
module prog_loader #(
    parameter int D = 12,
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [D-1:0] len,
    input  logic         in_valid,
    input  logic [7:0]   in_byte,
    output logic         in_ready,
    output logic         imem_we,
    output logic [D-1:0] imem_addr,
    output logic [W-1:0] imem_data,
    input  logic         core_done,
    output logic         core_reset,
    output logic         busy,
    output logic         halted
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LO,
        LOAD_HI,
        FLUSH,
        RUN,
        HALT
    } state_t;

    state_t       state, next_state;
    logic [D-1:0] count, next_count;
    logic [D-1:0] len_q, next_len;
    logic [7:0]   low_q, next_low;
    logic [D-1:0] count_inc;
    logic [8:0]   raw_word;
    logic         take;
    logic         wr;
    logic         accept;

    assign take      = in_valid && in_ready;
    assign count_inc = count + D'(1);
    assign raw_word  = {in_byte[0], low_q};

    always_comb begin
        next_state = state;
        next_count = count;
        next_len   = len_q;
        next_low   = low_q;
        wr         = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    accept     = 1'b1;
                    next_len   = len;
                    next_count = '0;
                    next_state = (len == '0) ? FLUSH : LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (take) begin
                    next_low   = in_byte;
                    next_state = LOAD_HI;
                end
            end
            LOAD_HI: begin
                if (take) begin
                    wr         = 1'b1;
                    next_count = count_inc;
                    next_state = (count_inc == len_q) ? FLUSH : LOAD_LO;
                end
            end
            FLUSH:   next_state = RUN;
            RUN: begin
                if (core_done) begin
                    next_state = HALT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every one of them is a flop
    // that lines up exactly with the state it describes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            len_q      <= '0;
            low_q      <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_data  <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= next_state;
            count      <= next_count;
            len_q      <= next_len;
            low_q      <= next_low;
            imem_we    <= wr;
            if (wr) begin
                imem_addr <= count;
                imem_data <= W'(raw_word);
            end else if (accept) begin
                imem_addr <= '0;
            end
            in_ready   <= (next_state == LOAD_LO) || (next_state == LOAD_HI);
            busy       <= (next_state == LOAD_LO) || (next_state == LOAD_HI) ||
                          (next_state == FLUSH);
            halted     <= (next_state == HALT);
            core_reset <= (next_state != RUN);
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scenario tasks with inline checks plus a
// write scoreboard fed by the stimulus and drained by an imem_we monitor.
module tb_prog_loader;

    localparam int D = 12;
    localparam int W = 9;

    logic         clk;
    logic         reset;
    logic         start;
    logic [D-1:0] len;
    logic         in_valid;
    logic [7:0]   in_byte;
    logic         in_ready;
    logic         imem_we;
    logic [D-1:0] imem_addr;
    logic [W-1:0] imem_data;
    logic         core_done;
    logic         core_reset;
    logic         busy;
    logic         halted;

    int vectors;
    int miscompares;
    int write_count;

    logic [D+W-1:0] sb[$];
    logic [D+W-1:0] sb_exp;
    logic [4:0]     status;

    prog_loader #(.D(D), .W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .core_done  (core_done),
        .core_reset (core_reset),
        .busy       (busy),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    assign status = {in_ready, imem_we, busy, halted, core_reset};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs forever, checking every write strobe against the scoreboard head.
    task automatic run_monitor();
        forever begin
            @(negedge clk);
            if (imem_we) begin
                write_count++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_write: got addr=%0h data=%0h, expected no write",
                             imem_addr, imem_data);
                end else begin
                    sb_exp = sb.pop_front();
                    if ({imem_addr, imem_data} !== sb_exp) begin
                        miscompares++;
                        $display("[TB] FAIL write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                                 imem_addr, imem_data, sb_exp[D+W-1:W], sb_exp[W-1:0]);
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [D-1:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
        len   = ~n;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL send_byte: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [D-1:0] addr, input logic [7:0] lo, input logic [7:0] hi);
        logic [8:0] word;
        word = {hi[0], lo};
        sb.push_back({addr, W'(word)});
        send_byte(lo);
        send_byte(hi);
    endtask

    task automatic checkOutput(input string name, input logic [4:0] expected);
        @(negedge clk);
        vectors++;
        if (status !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got {rdy,we,busy,halt,crst}=%b, expected %b", name, status, expected);
        end
    endtask

    task automatic go_halt();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        checkOutput("reset_status", 5'b00001);
        vectors++;
        if ({imem_addr, imem_data} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_addr_data: got %0h/%0h, expected 0/0", imem_addr, imem_data);
        end
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("idle_after_reset", 5'b00001);
    endtask

    task automatic test_load();
        int wc;
        wc = write_count;
        applyStimulus(2);
        checkOutput("load_start", 5'b10101);
        send_word(0, 8'hA5, 8'h01);
        send_word(1, 8'h3C, 8'h00);
        checkOutput("load_flush", 5'b01101);
        tick();
        checkOutput("load_run", 5'b00000);
        vectors++;
        if (write_count - wc !== 2) begin
            miscompares++;
            $display("[TB] FAIL load_writes: got %0d, expected 2", write_count - wc);
        end
    endtask

    task automatic test_ignored_start_run();
        applyStimulus(5);
        checkOutput("start_in_run", 5'b00000);
        vectors++;
        if (imem_addr !== 1) begin
            miscompares++;
            $display("[TB] FAIL start_in_run_addr: got %0h, expected 1", imem_addr);
        end
    endtask

    task automatic test_done();
        go_halt();
        checkOutput("halt", 5'b00011);
        applyStimulus(1);
        checkOutput("reload_from_halt", 5'b10101);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checkOutput("done_ignored_in_load", 5'b10101);
        send_word(0, 8'hFF, 8'hFE);
        checkOutput("done_flush", 5'b01101);
        tick();
        checkOutput("done_run", 5'b00000);
    endtask

    task automatic test_zero_len();
        int wc;
        go_halt();
        wc = write_count;
        applyStimulus(0);
        checkOutput("zero_flush", 5'b00101);
        tick();
        checkOutput("zero_run", 5'b00000);
        vectors++;
        if (write_count !== wc) begin
            miscompares++;
            $display("[TB] FAIL zero_writes: got %0d, expected %0d", write_count, wc);
        end
    endtask

    task automatic test_stall();
        go_halt();
        applyStimulus(2);
        send_word(0, 8'h34, 8'h00);
        sb.push_back({D'(1), W'(9'h112)});
        send_byte(8'h12);
        for (int i = 0; i < 2; i++) begin
            checkOutput("stall_hold", 5'b10101);
            tick();
        end
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        tick();
        in_valid = 1'b0;
        checkOutput("stall_write", 5'b01101);
        tick();
        checkOutput("stall_run", 5'b00000);
    endtask

    task automatic test_ignored_start_load();
        go_halt();
        applyStimulus(3);
        applyStimulus(1);
        checkOutput("start_in_load", 5'b10101);
        send_word(0, 8'h11, 8'h00);
        send_word(1, 8'h22, 8'h01);
        checkOutput("len_kept", 5'b11101);
        send_word(2, 8'h33, 8'h00);
        checkOutput("ign_flush", 5'b01101);
        tick();
        checkOutput("ign_run", 5'b00000);
    endtask

    task automatic test_reset_midload();
        int wc;
        go_halt();
        wc = write_count;
        applyStimulus(5);
        for (int i = 0; i < 3; i++) send_word(D'(i), 8'h40 + 8'(i), 8'(i));
        send_byte(8'h77);
        reset = 1'b0;
        #2;
        vectors++;
        if (status !== 5'b00001 || imem_addr !== '0 || imem_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got status=%b addr=%0h data=%0h, expected 00001/0/0",
                     status, imem_addr, imem_data);
        end
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) tick();
        checkOutput("post_reset_idle", 5'b00001);
        vectors++;
        if (write_count - wc !== 3) begin
            miscompares++;
            $display("[TB] FAIL partial_discard: got %0d writes, expected 3", write_count - wc);
        end
        applyStimulus(2);
        send_word(0, 8'h5A, 8'h01);
        send_word(1, 8'hC3, 8'h00);
        checkOutput("reload_flush", 5'b01101);
        tick();
        checkOutput("reload_run", 5'b00000);
    endtask

    task automatic test_max_len();
        logic [7:0] lo, hi;
        go_halt();
        applyStimulus(D'((1 << D) - 1));
        for (int i = 0; i < (1 << D) - 1; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom);
            send_word(D'(i), lo, hi);
        end
        checkOutput("max_flush", 5'b01101);
        vectors++;
        if (imem_addr !== D'((1 << D) - 2)) begin
            miscompares++;
            $display("[TB] FAIL max_last_addr: got %0h, expected %0h", imem_addr, (1 << D) - 2);
        end
        tick();
        checkOutput("max_run", 5'b00000);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        write_count = 0;
        start       = 1'b0;
        len         = '0;
        in_valid    = 1'b0;
        in_byte     = '0;
        core_done   = 1'b0;
        reset       = 1'b0;
        fork
            run_monitor();
        join_none
        test_reset();
        test_load();
        test_ignored_start_run();
        test_done();
        test_zero_len();
        test_stall();
        test_ignored_start_load();
        test_reset_midload();
        test_max_len();
        repeat (2) tick();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: %0d writes outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter D, default 12, program-counter/instruction-address width.
REQ-002 Parameter W, default 9, machine-code word width.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse requesting a new program load.
REQ-006 len  input  D  number of words to load, sampled only when start is accepted.
REQ-007 in_valid  input  1  a byte is offered on in_byte.
REQ-008 in_byte  input  8  program byte stream: low byte first, then high byte (bit 0 only used).
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 imem_we  output  1  instruction-memory write strobe.
REQ-011 imem_addr  output  D  instruction-memory write address.
REQ-012 imem_data  output  W  instruction-memory write word.
REQ-013 core_done  input  1  core's done flag.
REQ-014 core_reset  output  1  active-high reset to the core; 1 holds the core.
REQ-015 busy  output  1  a load is in progress.
REQ-016 halted  output  1  the core has signalled done since the last load.

Function
REQ-017 The loader SHALL implement the states IDLE, LOAD_LO, LOAD_HI, FLUSH, RUN and HALT, with all outputs registered.
REQ-018 In IDLE or HALT, start=1 SHALL latch len, clear the word counter to 0 and go to LOAD_LO, or to FLUSH if len=0.
REQ-019 start SHALL be ignored in LOAD_LO, LOAD_HI, FLUSH and RUN.
REQ-020 in_ready SHALL be 1 exactly in LOAD_LO and LOAD_HI, and a byte SHALL transfer only on a cycle with in_valid=1 and in_ready=1.
REQ-021 A transfer in LOAD_LO SHALL store in_byte as the low byte and go to LOAD_HI.
REQ-022 A transfer in LOAD_HI SHALL, on the next cycle, drive imem_we=1 for one cycle, with imem_addr=counter and imem_data={in_byte[0], low byte}.
REQ-023 After a LOAD_HI transfer, the counter SHALL increment, and the state SHALL go to FLUSH if the new counter equals len, otherwise back to LOAD_LO.
REQ-024 With in_valid=0 the state and counter SHALL hold, and no write SHALL occur.
REQ-025 FLUSH SHALL last exactly one cycle, during which the final imem_we pulse completes, and SHALL then go to RUN.
REQ-026 core_reset SHALL be 0 only in RUN, so the core first fetches address 0 on the cycle after FLUSH.
REQ-027 In RUN, core_done=1 SHALL move the state to HALT on the next edge; core_done SHALL be ignored in all other states.
REQ-028 busy SHALL be 1 in LOAD_LO, LOAD_HI and FLUSH.
REQ-029 halted SHALL be 1 only in HALT.
REQ-030 imem_we SHALL never be asserted outside the cycle following a LOAD_HI transfer.
REQ-031 imem_addr SHALL never exceed len-1, and the counter SHALL NOT wrap; a len of 2^D-1 SHALL load addresses 0..2^D-2.
REQ-032 Bits 7:1 of the high byte SHALL be discarded.

Reset
REQ-033 Asserting reset (0) at any time, including mid-load, SHALL immediately force IDLE, counter=0, core_reset=1, in_ready=0, imem_we=0, imem_addr=0, imem_data=0, busy=0 and halted=0.
REQ-034 A partially assembled word SHALL be discarded on reset and never written.
REQ-035 After reset deassertion, the loader SHALL remain in IDLE until start.

Verification
REQ-036 Load: start, len=2, bytes 0xA5,0x01,0x3C,0x00 -> writes (addr 0, 0x1A5) and (addr 1, 0x03C), then FLUSH, then core_reset falls.
REQ-037 Stall: in_valid toggled 1,0,0,1 during LOAD_HI -> exactly one write, occurring one cycle after the second valid, and the counter unchanged while stalled.
REQ-038 Zero length: start with len=0 -> no imem_we, IDLE->FLUSH->RUN, core_reset=0 two cycles after start.
REQ-039 Done: core_done=1 in RUN -> HALT, halted=1, core_reset=1; a following start with len=1 and bytes 0xFF,0xFE -> write (0, 0x0FF).
REQ-040 Reset mid-load: reset low after the low byte of word 3 -> all outputs at reset values; after release, a new start reloads from address 0.
REQ-041 Ignored start: start pulsed during LOAD_LO and during RUN -> no change to state, counter or latched len.
